seven_seg_scan: RTL and testbench

- Downstream consumer of the CPU top-level's debug outputs: x (current PC) and y (write-back data).
- Drives an 8-digit multiplexed seven-segment display, time-sharing one segment bus across digits.
- Snapshots x/y once per full scan frame so digits never tear mid-frame; supports freeze, halfword page select and leading-zero blanking.
- Hex-to-segment decode is the only combinational piece; everything else is counters and registers.

---
 rtl/seven_seg_scan_pkg.sv | 21 ++
 rtl/seven_seg_scan_hex_to_seg.sv | 11 +
 rtl/seven_seg_scan.sv | 87 ++++++++
 tb/tb_seven_seg_scan.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_scan_pkg.sv
// rtl/seven_seg_scan_pkg.sv - shared constants and types for the seven-segment scanner
package seven_seg_scan_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] DIG_OFF   = 8'hFF;

  // Active-low segment patterns, bit0=a .. bit6=g; entry n is the glyph for hex digit n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef logic [2:0] digit_idx_t;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic        page;
  } snap_t;

endpackage

// File: rtl/seven_seg_scan_hex_to_seg.sv
// rtl/seven_seg_scan_hex_to_seg.sv - combinational hex nibble to active-low segment decoder
module hex_to_seg
  import seven_seg_scan_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - 8-digit multiplexed display driver with per-frame snapshot of x/y
module seven_seg_scan
  import seven_seg_scan_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        Clk,
  input  logic        rst,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        page,
  input  logic        freeze,
  input  logic        blank_lz,
  output logic [6:0]  out7,
  output logic [7:0]  en_out
);

  localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  digit_idx_t       idx_q, idx_d;
  snap_t            snap_q, snap_d;
  logic [6:0]       out7_q, out7_d;
  logic [7:0]       en_q, en_d;

  logic        tick;
  logic        capture;
  logic [15:0] hw_x, hw_y, group;
  logic [1:0]  pos;
  logic [3:0]  nib;
  logic        upper_zero;
  logic        blank;
  logic [6:0]  seg_dec;

  assign tick    = (div_cnt_q == DIV_LAST);
  // Snapshot only at the frame boundary so a frame never mixes old and new digits.
  assign capture = tick && (idx_q == 3'd7) && !freeze;

  assign hw_x  = snap_q.page ? snap_q.x[31:16] : snap_q.x[15:0];
  assign hw_y  = snap_q.page ? snap_q.y[31:16] : snap_q.y[15:0];
  assign group = idx_q[2] ? hw_y : hw_x;
  assign pos   = idx_q[1:0];
  assign nib   = group[{pos, 2'b00} +: 4];

  // The digit and everything above it in its group must be zero to be a leading zero.
  assign upper_zero = ((group >> {pos, 2'b00}) == 16'd0);
  assign blank      = blank_lz && (pos != 2'd0) && upper_zero;

  hex_to_seg u_hex_to_seg (
    .nib_i (nib),
    .seg_o (seg_dec)
  );

  always_comb begin
    div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
    idx_d     = tick ? idx_q + 3'd1 : idx_q;
    snap_d    = snap_q;
    if (capture) begin
      snap_d.x    = x;
      snap_d.y    = y;
      snap_d.page = page;
    end
    en_d   = ~(8'b1 << idx_q);
    out7_d = blank ? SEG_BLANK : seg_dec;
  end

  always_ff @(posedge Clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      idx_q     <= '0;
      snap_q    <= '0;
      out7_q    <= SEG_BLANK;
      en_q      <= DIG_OFF;
    end else begin
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      out7_q    <= out7_d;
      en_q      <= en_d;
    end
  end

  assign out7   = out7_q;
  assign en_out = en_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb/tb_seven_seg_scan.sv - self-checking bench for seven_seg_scan with a cycle-count reference model
module tb_seven_seg_scan;

  localparam int RD    = 4;
  localparam int FRAME = 8 * RD;

  logic        Clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic        page = 1'b0;
  logic        freeze = 1'b0;
  logic        blank_lz = 1'b0;
  logic [6:0]  out7;
  logic [7:0]  en_out;

  int total = 0;
  int bad   = 0;

  seven_seg_scan #(.REFRESH_DIV(RD)) dut (
    .Clk      (Clk),
    .rst      (rst),
    .x        (x),
    .y        (y),
    .page     (page),
    .freeze   (freeze),
    .blank_lz (blank_lz),
    .out7     (out7),
    .en_out   (en_out)
  );

  always #5 Clk = ~Clk;

  // Reference model: position in the scan follows from cycles elapsed since reset.
  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int          m_cyc = 0;
  logic [31:0] m_x = '0;
  logic [31:0] m_y = '0;
  logic        m_page = 1'b0;
  logic [6:0]  exp7 = 7'h7F;
  logic [7:0]  exp_en = 8'hFF;

  function automatic logic [6:0] model_seg(input int d);
    logic [31:0] word;
    int          p;
    int          half;
    int          n;
    word = (d < 4) ? m_x : m_y;
    half = m_page ? int'(word[31:16]) : int'(word[15:0]);
    p    = d % 4;
    n    = (half >> (4 * p)) % 16;
    if (blank_lz && p != 0 && (half >> (4 * p)) == 0) return 7'h7F;
    return hex_tab[n];
  endfunction

  always @(posedge Clk) begin
    if (rst) begin
      m_cyc  <= 0;
      m_x    <= '0;
      m_y    <= '0;
      m_page <= 1'b0;
      exp7   <= 7'h7F;
      exp_en <= 8'hFF;
    end else begin
      exp_en <= ~(8'b1 << ((m_cyc / RD) % 8));
      exp7   <= model_seg((m_cyc / RD) % 8);
      if (m_cyc % FRAME == FRAME - 1 && !freeze) begin
        m_x    <= x;
        m_y    <= y;
        m_page <= page;
      end
      m_cyc <= m_cyc + 1;
    end
  end

  task automatic wait_frame_start();
    int n;
    n = 0;
    while (m_cyc % FRAME != 1 && n < 4 * FRAME) begin
      @(negedge Clk);
      n++;
    end
    total++;
    if (m_cyc % FRAME != 1) begin
      bad++;
      $display("FAIL frame_align got m_cyc=%0d want m_cyc%%%0d==1", m_cyc, FRAME);
    end
  endtask

  task automatic next_frame();
    @(negedge Clk);
    wait_frame_start();
  endtask

  // Entered while the display shows frame cycle 0; leaves at frame cycle 0 of the next frame.
  task automatic check_frame(input string name, input logic [7:0][6:0] e);
    for (int k = 0; k < FRAME; k++) begin
      total += 2;
      if (en_out !== ~(8'b1 << (k / RD))) begin
        bad++;
        $display("FAIL %s en k=%0d got %h want %h", name, k, en_out, ~(8'b1 << (k / RD)));
      end
      if (out7 !== e[k / RD]) begin
        bad++;
        $display("FAIL %s out7 k=%0d got %h want %h", name, k, out7, e[k / RD]);
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge Clk);
    total += 2;
    if (out7 !== 7'h7F) begin bad++; $display("FAIL reset_out7 got %h want 7f", out7); end
    if (en_out !== 8'hFF) begin bad++; $display("FAIL reset_en got %h want ff", en_out); end
    rst = 1'b0;
    @(negedge Clk);
    total += 2;
    if (en_out !== 8'hFE) begin bad++; $display("FAIL post_reset_en got %h want fe", en_out); end
    if (out7 !== 7'h40) begin bad++; $display("FAIL post_reset_out7 got %h want 40", out7); end
  endtask

  task automatic test_normal();
    x = 32'h0000_1234; y = 32'h0000_ABCD; page = 1'b0; blank_lz = 1'b0;
    next_frame();
    check_frame("normal", {7'h08, 7'h03, 7'h46, 7'h21, 7'h79, 7'h24, 7'h30, 7'h19});
  endtask

  task automatic test_blanking();
    x = 32'h0000_0005; y = 32'h0; blank_lz = 1'b1;
    next_frame();
    check_frame("blank", {7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h12});
    blank_lz = 1'b0;
  endtask

  task automatic test_page();
    x = 32'hDEAD_0000; y = 32'h0; page = 1'b0;
    next_frame();
    page = 1'b1;
    check_frame("page_hold", {8{7'h40}});
    check_frame("page_hi", {7'h40, 7'h40, 7'h40, 7'h40, 7'h21, 7'h06, 7'h08, 7'h21});
    page = 1'b0;
  endtask

  task automatic test_freeze();
    x = 32'h0000_1234; y = 32'h0;
    next_frame();
    freeze = 1'b1;
    x = 32'h0000_5678;
    check_frame("freeze_a", {7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h30, 7'h19});
    freeze = 1'b0;
    check_frame("freeze_b", {7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h30, 7'h19});
    check_frame("unfreeze", {7'h40, 7'h40, 7'h40, 7'h40, 7'h12, 7'h02, 7'h78, 7'h00});
  endtask

  task automatic test_mid_reset();
    wait_frame_start();
    repeat (5 * RD) @(negedge Clk);
    rst = 1'b1;
    @(negedge Clk);
    total += 2;
    if (out7 !== 7'h7F) begin bad++; $display("FAIL midrst_out7 got %h want 7f", out7); end
    if (en_out !== 8'hFF) begin bad++; $display("FAIL midrst_en got %h want ff", en_out); end
    rst = 1'b0;
    @(negedge Clk);
    check_frame("after_midrst", {8{7'h40}});
  endtask

  task automatic test_random();
    for (int k = 0; k < 12 * FRAME; k++) begin
      total += 2;
      if (en_out !== exp_en) begin
        bad++;
        $display("FAIL rand_en k=%0d got %h want %h", k, en_out, exp_en);
      end
      if (out7 !== exp7) begin
        bad++;
        $display("FAIL rand_out7 k=%0d got %h want %h", k, out7, exp7);
      end
      if ($urandom_range(0, 7) == 0) x = $urandom & ((($urandom % 2) == 0) ? 32'h00FF_00FF : 32'hFFFF_FFFF);
      if ($urandom_range(0, 7) == 0) y = $urandom & ((($urandom % 2) == 0) ? 32'h000F_000F : 32'hFFFF_FFFF);
      if ($urandom_range(0, 5) == 0) page = 1'($urandom);
      if ($urandom_range(0, 5) == 0) freeze = 1'($urandom);
      if ($urandom_range(0, 5) == 0) blank_lz = 1'($urandom);
      @(negedge Clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_normal();
    test_blanking();
    test_page();
    test_freeze();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
